// File: rtl/aes_axil_pkg.sv
// Shared definitions for the AES AXI4-Lite register slice.
//   - register byte offsets, register count and width
//   - AXI response code
//   - write-channel FSM state type
//   - helpers for register select and byte-lane merge
package aes_axil_pkg;

    localparam int NUM_REGS = 4;
    localparam int REG_W    = 32;

    localparam logic [3:0] ADDR_REG0 = 4'h0;
    localparam logic [3:0] ADDR_REG1 = 4'h4;
    localparam logic [3:0] ADDR_REG2 = 4'h8;
    localparam logic [3:0] ADDR_REG3 = 4'hC;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HAVE_ADDR = 2'd1,
        HAVE_DATA = 2'd2,
        RESP      = 2'd3
    } wr_state_t;

    // Word select from a byte address; the low two bits are don't-care.
    function automatic logic [1:0] reg_idx(input logic [3:0] addr);
        return addr[3:2];
    endfunction

    // Replace only the byte lanes whose strobe bit is set.
    function automatic logic [REG_W-1:0] apply_wstrb(input logic [REG_W-1:0] old_val,
                                                     input logic [REG_W-1:0] new_val,
                                                     input logic [3:0]       strb);
        logic [REG_W-1:0] merged;
        merged = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                merged[8*b +: 8] = new_val[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/aes_axil_regs.sv
// AXI4-Lite slave exposing four 32-bit configuration registers.
//
// Ports:
//   ACLK, ARESET        clock, asynchronous active-high reset
//   S_AXI_AW*/W*/B*     write address / data / response channels
//   S_AXI_AR*/R*        read address / data channels
//   regs_o              all four registers, reg0 in [31:0]
//   wr_pulse_o          bit k high for one cycle after register k is written
//
// Write FSM:
//   state     | meaning
//   IDLE      | waiting for AW and/or W
//   HAVE_ADDR | address latched, waiting for W
//   HAVE_DATA | data + strobe latched, waiting for AW
//   RESP      | register updated, BVALID held until BREADY
module aes_axil_regs
    import aes_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [NUM_REGS*REG_W-1:0]       regs_o,
    output logic [NUM_REGS-1:0]             wr_pulse_o
);

    wr_state_t          wr_state_q, wr_state_d;
    logic [1:0]         awaddr_q;
    logic [REG_W-1:0]   wdata_q;
    logic [3:0]         wstrb_q;
    logic [REG_W-1:0]   regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] wr_pulse_q;
    logic [REG_W-1:0]   rdata_q;
    logic               rvalid_q;

    logic               aw_hs, w_hs, ar_hs;
    logic               wr_commit;
    logic [1:0]         commit_idx;
    logic [REG_W-1:0]   commit_data;
    logic [3:0]         commit_strb;

    logic               unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT};

    // Readies are gated by reset so they read low while ARESET is held,
    // and follow the state as soon as it is released.
    assign S_AXI_AWREADY = !ARESET && (wr_state_q == IDLE || wr_state_q == HAVE_DATA);
    assign S_AXI_WREADY  = !ARESET && (wr_state_q == IDLE || wr_state_q == HAVE_ADDR);
    assign S_AXI_ARREADY = !ARESET && !rvalid_q;

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    always_comb begin
        wr_state_d = wr_state_q;
        case (wr_state_q)
            IDLE: begin
                if (aw_hs && w_hs)  wr_state_d = RESP;
                else if (aw_hs)     wr_state_d = HAVE_ADDR;
                else if (w_hs)      wr_state_d = HAVE_DATA;
            end
            HAVE_ADDR: if (w_hs)         wr_state_d = RESP;
            HAVE_DATA: if (aw_hs)        wr_state_d = RESP;
            RESP:      if (S_AXI_BREADY) wr_state_d = IDLE;
            default:                     wr_state_d = IDLE;
        endcase
    end

    // The update happens on the edge that enters RESP; whichever half of the
    // transaction arrives last is taken straight from the bus.
    assign wr_commit   = (wr_state_q != RESP) && (wr_state_d == RESP);
    assign commit_idx  = (wr_state_q == HAVE_ADDR) ? awaddr_q : reg_idx(S_AXI_AWADDR);
    assign commit_data = (wr_state_q == HAVE_DATA) ? wdata_q  : S_AXI_WDATA;
    assign commit_strb = (wr_state_q == HAVE_DATA) ? wstrb_q  : S_AXI_WSTRB;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_state_q <= IDLE;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            wr_pulse_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            wr_state_q <= wr_state_d;
            if (aw_hs) begin
                awaddr_q <= reg_idx(S_AXI_AWADDR);
            end
            if (w_hs) begin
                wdata_q <= S_AXI_WDATA;
                wstrb_q <= S_AXI_WSTRB;
            end
            wr_pulse_q <= '0;
            if (wr_commit) begin
                regs_q[commit_idx]     <= apply_wstrb(regs_q[commit_idx], commit_data, commit_strb);
                wr_pulse_q[commit_idx] <= 1'b1;
            end
        end
    end

    // Read side samples regs_q before any same-edge write lands.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else if (ar_hs) begin
            rdata_q  <= regs_q[reg_idx(S_AXI_ARADDR)];
            rvalid_q <= 1'b1;
        end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_q <= 1'b0;
        end
    end

    assign S_AXI_BVALID = (wr_state_q == RESP);
    assign S_AXI_BRESP  = RESP_OKAY;
    assign S_AXI_RDATA  = rdata_q;
    assign S_AXI_RRESP  = RESP_OKAY;
    assign S_AXI_RVALID = rvalid_q;
    assign regs_o       = {regs_q[3], regs_q[2], regs_q[1], regs_q[0]};
    assign wr_pulse_o   = wr_pulse_q;

endmodule

// File: tb/tb_aes_axil_regs.sv
module tb_aes_axil_regs;
    import aes_axil_pkg::*;

    logic         ACLK = 1'b0;
    logic         ARESET;
    logic [3:0]   S_AXI_AWADDR;
    logic [2:0]   S_AXI_AWPROT;
    logic         S_AXI_AWVALID;
    logic         S_AXI_AWREADY;
    logic [31:0]  S_AXI_WDATA;
    logic [3:0]   S_AXI_WSTRB;
    logic         S_AXI_WVALID;
    logic         S_AXI_WREADY;
    logic [1:0]   S_AXI_BRESP;
    logic         S_AXI_BVALID;
    logic         S_AXI_BREADY;
    logic [3:0]   S_AXI_ARADDR;
    logic [2:0]   S_AXI_ARPROT;
    logic         S_AXI_ARVALID;
    logic         S_AXI_ARREADY;
    logic [31:0]  S_AXI_RDATA;
    logic [1:0]   S_AXI_RRESP;
    logic         S_AXI_RVALID;
    logic         S_AXI_RREADY;
    logic [127:0] regs_o;
    logic [3:0]   wr_pulse_o;

    aes_axil_regs dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .regs_o        (regs_o),
        .wr_pulse_o    (wr_pulse_o)
    );

    always #5 ACLK = ~ACLK;

    int checks   = 0;
    int failures = 0;

    logic [1:0]  exp_b[$];
    logic [31:0] exp_r[$];
    int          pulse_cnt[4] = '{0, 0, 0, 0};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s timeout actual=no_handshake expected=handshake t=%0t", name, $time);
    endtask

    // Monitor: handshakes seen at the falling edge complete on the next rising edge.
    always @(negedge ACLK) begin
        if (!ARESET) begin
            if (S_AXI_BVALID && S_AXI_BREADY) begin
                if (exp_b.size() == 0) begin
                    timeout_fail("b_unexpected");
                end else begin
                    check("bresp", S_AXI_BRESP, exp_b.pop_front());
                end
            end
            if (S_AXI_RVALID && S_AXI_RREADY) begin
                if (exp_r.size() == 0) begin
                    timeout_fail("r_unexpected");
                end else begin
                    check("rdata", S_AXI_RDATA, exp_r.pop_front());
                    check("rresp", S_AXI_RRESP, RESP_OKAY);
                end
            end
            for (int k = 0; k < 4; k++) begin
                pulse_cnt[k] += int'(wr_pulse_o[k]);
            end
        end
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input bit chk_lat);
        bit aw_done, w_done, aw_now, w_now;
        int n;
        logic [3:0] exp_pulse;
        exp_b.push_back(RESP_OKAY);
        S_AXI_AWADDR  = addr;
        S_AXI_WDATA   = data;
        S_AXI_WSTRB   = strb;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        aw_done = 0; w_done = 0; n = 0;
        while (!(aw_done && w_done) && n < 20) begin
            @(negedge ACLK);
            aw_now = S_AXI_AWVALID && S_AXI_AWREADY;
            w_now  = S_AXI_WVALID && S_AXI_WREADY;
            tick();
            if (aw_now) begin aw_done = 1; S_AXI_AWVALID = 1'b0; end
            if (w_now)  begin w_done  = 1; S_AXI_WVALID  = 1'b0; end
            n++;
        end
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        if (!(aw_done && w_done)) timeout_fail("aw_w_handshake");
        if (chk_lat) begin
            exp_pulse = 4'b0001 << addr[3:2];
            check("b_latency", S_AXI_BVALID, 1'b1);
            check("wr_pulse", wr_pulse_o, exp_pulse);
        end
    endtask

    task automatic wait_b();
        int n;
        bit done;
        done = 0;
        for (n = 0; n < 30 && !done; n++) begin
            @(negedge ACLK);
            if (S_AXI_BVALID && S_AXI_BREADY) done = 1;
            tick();
        end
        if (!done) timeout_fail("b_handshake");
    endtask

    task automatic wait_r();
        int n;
        bit done;
        done = 0;
        for (n = 0; n < 30 && !done; n++) begin
            @(negedge ACLK);
            if (S_AXI_RVALID && S_AXI_RREADY) done = 1;
            tick();
        end
        if (!done) timeout_fail("r_handshake");
    endtask

    task automatic issue_ar(input logic [3:0] addr);
        int n;
        bit done;
        S_AXI_ARADDR  = addr;
        S_AXI_ARVALID = 1'b1;
        done = 0;
        for (n = 0; n < 20 && !done; n++) begin
            @(negedge ACLK);
            if (S_AXI_ARVALID && S_AXI_ARREADY) done = 1;
            tick();
        end
        S_AXI_ARVALID = 1'b0;
        if (!done) timeout_fail("ar_handshake");
    endtask

    task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp);
        exp_r.push_back(exp);
        issue_ar(addr);
        wait_r();
    endtask

    int p1_before;

    initial begin
        ARESET        = 1'b1;
        S_AXI_AWADDR  = '0;
        S_AXI_AWPROT  = '0;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA   = '0;
        S_AXI_WSTRB   = '0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_BREADY  = 1'b1;
        S_AXI_ARADDR  = '0;
        S_AXI_ARPROT  = '0;
        S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY  = 1'b1;

        // Reset state
        #3;
        check("rst_awready", S_AXI_AWREADY, 1'b0);
        check("rst_wready",  S_AXI_WREADY,  1'b0);
        check("rst_arready", S_AXI_ARREADY, 1'b0);
        check("rst_bvalid",  S_AXI_BVALID,  1'b0);
        check("rst_rvalid",  S_AXI_RVALID,  1'b0);
        check("rst_regs",    regs_o,        128'h0);
        check("rst_pulse",   wr_pulse_o,    4'h0);
        repeat (2) tick();
        ARESET = 1'b0;
        #1;
        check("post_rst_awready", S_AXI_AWREADY, 1'b1);
        check("post_rst_wready",  S_AXI_WREADY,  1'b1);
        check("post_rst_arready", S_AXI_ARREADY, 1'b1);
        tick();

        // Four writes with AW+W together, then read back
        axi_write(ADDR_REG0, 32'd1, 4'hF, 1); wait_b();
        axi_write(ADDR_REG1, 32'd2, 4'hF, 1); wait_b();
        axi_write(ADDR_REG2, 32'd3, 4'hF, 1); wait_b();
        axi_write(ADDR_REG3, 32'd4, 4'hF, 1); wait_b();
        axi_read(ADDR_REG0, 32'd1);
        axi_read(ADDR_REG1, 32'd2);
        axi_read(ADDR_REG2, 32'd3);
        axi_read(ADDR_REG3, 32'd4);
        check("regs_o_1234", regs_o, 128'h00000004_00000003_00000002_00000001);

        // Byte strobes on register 1, including an all-zero strobe
        p1_before = pulse_cnt[1];
        axi_write(ADDR_REG1, 32'hAABBCCDD, 4'hF, 1);    wait_b();
        axi_write(ADDR_REG1, 32'h11223344, 4'b0101, 1); wait_b();
        axi_read(ADDR_REG1, 32'hAA22CC44);
        check("pulse1_twice", pulse_cnt[1] - p1_before, 2);
        axi_write(ADDR_REG1, 32'hFFFFFFFF, 4'b0000, 1); wait_b();
        axi_read(ADDR_REG1, 32'hAA22CC44);
        check("pulse1_strb0", pulse_cnt[1] - p1_before, 3);

        // W three cycles ahead of AW
        exp_b.push_back(RESP_OKAY);
        S_AXI_WDATA  = 32'h5A5A5A5A;
        S_AXI_WSTRB  = 4'hF;
        S_AXI_WVALID = 1'b1;
        issue_w: begin
            bit done;
            done = 0;
            for (int n = 0; n < 20 && !done; n++) begin
                @(negedge ACLK);
                if (S_AXI_WREADY) done = 1;
                tick();
            end
            if (!done) timeout_fail("w_only_handshake");
        end
        S_AXI_WVALID = 1'b0;
        check("have_data_wready",  S_AXI_WREADY,  1'b0);
        check("have_data_awready", S_AXI_AWREADY, 1'b1);
        repeat (2) tick();
        check("have_data_wready_hold", S_AXI_WREADY, 1'b0);
        check("have_data_bvalid",      S_AXI_BVALID, 1'b0);
        S_AXI_AWADDR  = ADDR_REG2;
        S_AXI_AWVALID = 1'b1;
        @(negedge ACLK);
        check("late_aw_awready", S_AXI_AWREADY, 1'b1);
        tick();
        S_AXI_AWVALID = 1'b0;
        check("late_aw_bvalid", S_AXI_BVALID, 1'b1);
        check("late_aw_pulse",  wr_pulse_o,   4'b0100);
        check("late_aw_regs_o", regs_o[95:64], 32'h5A5A5A5A);
        wait_b();
        axi_read(ADDR_REG2, 32'h5A5A5A5A);

        // BREADY held low while a read of 0xC completes
        S_AXI_BREADY = 1'b0;
        axi_write(ADDR_REG3, 32'hC0FFEE00, 4'hF, 1);
        for (int i = 0; i < 5; i++) begin
            check("bhold_bvalid",  S_AXI_BVALID,  1'b1);
            check("bhold_awready", S_AXI_AWREADY, 1'b0);
            check("bhold_wready",  S_AXI_WREADY,  1'b0);
            if (i == 1) axi_read(ADDR_REG3, 32'hC0FFEE00);
            else        tick();
        end
        S_AXI_BREADY = 1'b1;
        wait_b();

        // RREADY low while register 0 is rewritten
        S_AXI_RREADY = 1'b0;
        exp_r.push_back(32'd1);
        issue_ar(ADDR_REG0);
        axi_write(ADDR_REG0, 32'hDEADBEEF, 4'hF, 1);
        wait_b();
        for (int i = 0; i < 4; i++) begin
            check("rhold_rvalid", S_AXI_RVALID, 1'b1);
            check("rhold_rdata",  S_AXI_RDATA,  32'd1);
            tick();
        end
        S_AXI_RREADY = 1'b1;
        wait_r();
        axi_read(ADDR_REG0, 32'hDEADBEEF);

        // AR handshake on the same edge as the update returns the old value
        fork
            begin axi_write(ADDR_REG0, 32'h12345678, 4'hF, 0); wait_b(); end
            axi_read(ADDR_REG0, 32'hDEADBEEF);
        join
        axi_read(ADDR_REG0, 32'h12345678);

        // Reset while in HAVE_ADDR
        S_AXI_AWADDR  = ADDR_REG1;
        S_AXI_AWVALID = 1'b1;
        @(negedge ACLK);
        tick();
        S_AXI_AWVALID = 1'b0;
        check("have_addr_awready", S_AXI_AWREADY, 1'b0);
        check("have_addr_wready",  S_AXI_WREADY,  1'b1);
        #2 ARESET = 1'b1;
        #1;
        check("mid_rst_regs",    regs_o,        128'h0);
        check("mid_rst_wready",  S_AXI_WREADY,  1'b0);
        check("mid_rst_arready", S_AXI_ARREADY, 1'b0);
        check("mid_rst_rdata",   S_AXI_RDATA,   32'h0);
        tick();
        ARESET = 1'b0;
        #1;
        check("rel_awready", S_AXI_AWREADY, 1'b1);
        check("rel_wready",  S_AXI_WREADY,  1'b1);
        check("rel_bvalid",  S_AXI_BVALID,  1'b0);
        tick();
        check("rel_bvalid_later", S_AXI_BVALID, 1'b0);
        axi_read(ADDR_REG0, 32'h0);
        axi_read(ADDR_REG1, 32'h0);
        axi_read(ADDR_REG2, 32'h0);
        axi_read(ADDR_REG3, 32'h0);

        repeat (2) tick();
        check("b_queue_empty", exp_b.size(), 0);
        check("r_queue_empty", exp_r.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/aes_axil_regs.md
AES_AXIL_REGS -- requirements
Module: aes_axil_regs

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, byte address width covering four 32-bit registers.
REQ-003 SHALL have ports, in this order:
  ACLK  in  1  single clock, all logic rising-edge.
  ARESET  in  1  asynchronous, active-high reset.
  S_AXI_AWADDR  in  4  write address (bits [3:2] select register, [1:0] ignored).
  S_AXI_AWPROT  in  3  ignored.
  S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake.
  S_AXI_WDATA  in  32  write data.
  S_AXI_WSTRB  in  4  byte enables, bit n gates WDATA[8n+7:8n].
  S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake.
  S_AXI_BRESP  out  2  write response, always 2'b00 (OKAY).
  S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake.
  S_AXI_ARADDR  in  4  read address (bits [3:2] select register).
  S_AXI_ARPROT  in  3  ignored.
  S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake.
  S_AXI_RDATA  out  32  read data.
  S_AXI_RRESP  out  2  read response, always 2'b00.
  S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake.
  regs_o  out  128  registers 0..3 concatenated, reg0 in [31:0].
  wr_pulse_o  out  4  one-cycle pulse, bit k set in the cycle after register k is written.

Function
REQ-004 Write FSM SHALL have states IDLE, HAVE_ADDR, HAVE_DATA, RESP.
REQ-005 AWREADY SHALL be high only in IDLE and HAVE_DATA; WREADY SHALL be high only in IDLE and HAVE_ADDR.
REQ-006 IDLE: AW and W handshakes in the same cycle -> RESP; AW only -> HAVE_ADDR (address latched); W only -> HAVE_DATA (data and strobe latched).
REQ-007 HAVE_ADDR on W handshake -> RESP; HAVE_DATA on AW handshake -> RESP.
REQ-008 On entry to RESP, the selected register SHALL be updated byte-wise per WSTRB, BVALID set, and the matching wr_pulse_o bit pulsed for exactly one cycle.
REQ-009 In RESP, BVALID SHALL hold until BREADY is sampled high, then return to IDLE; no new AW/W is accepted while in RESP.
REQ-010 Best-case write latency: BVALID high one cycle after the simultaneous AW/W handshake.
REQ-011 WSTRB = 4'b0000 SHALL complete normally with OKAY and leave the register unchanged, while wr_pulse_o still pulses.
REQ-012 ARREADY SHALL be high whenever RVALID is low. On AR handshake, RDATA SHALL be loaded from the addressed register and RVALID set at the same edge. RDATA and RVALID SHALL hold until RREADY is high, then RVALID clears.
REQ-013 The read and write paths SHALL be independent. A read whose AR handshake occurs at the same edge as a register update SHALL return the pre-update value.
REQ-014 Register contents SHALL be reflected on regs_o in the cycle after the update edge.

Reset
REQ-015 ARESET high SHALL immediately and asynchronously force:
  - write FSM to IDLE;
  - all four registers, RDATA and regs_o to 0;
  - BVALID, RVALID, wr_pulse_o and ARREADY to 0;
  - AWREADY and WREADY to 0.
REQ-016 Reset asserted mid-transaction SHALL drop any latched address, data or pending response, with no register update.
REQ-017 Ready outputs SHALL become valid per REQ-005/REQ-012 in the first cycle after ARESET deasserts.

Structure
REQ-018 Package aes_axil_pkg SHALL hold the register offset constants (0x0, 0x4, 0x8, 0xC), RESP_OKAY, the register count (4) and the write-FSM state enum.
REQ-019 The block SHALL be a single module; no sub-module.

Verification
REQ-020 Scenario: write 1, 2, 3, 4 to 0x0/0x4/0x8/0xC with AW+W together, then read back -> RDATA 1, 2, 3, 4; every BRESP/RRESP = 0; regs_o = 0x00000004_00000003_00000002_00000001.
REQ-021 Scenario: write 0xAABBCCDD to 0x4, then 0x11223344 with WSTRB = 4'b0101 -> read of 0x4 returns 0xAA22CC44; wr_pulse_o[1] pulses twice.
REQ-022 Scenario: W presented 3 cycles before AW (addr 0x8, data 0x5A5A5A5A) -> WREADY low after W accepted, BVALID one cycle after AW handshake, register 2 = 0x5A5A5A5A.
REQ-023 Scenario: BREADY held low 5 cycles -> BVALID stays high, AWREADY/WREADY stay low, a concurrent read of 0xC still completes.
REQ-024 Scenario: RREADY low 4 cycles while register 0 is rewritten -> RDATA stays stable at the old value until the R handshake.
REQ-025 Scenario: ARESET pulsed while in HAVE_ADDR -> after release, FSM in IDLE, no BVALID, all registers read back 0.
